// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: PC register, byte-wide loadable instruction memory,
// big-endian word fetch with field decode, and the IDLE/LOAD/RUN/HALT sequencer.
module instruction_fetch_unit #(
    parameter int IMEM_BYTES = 128,
    parameter int LAW        = 7
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            load_en,
    input  logic [LAW-1:0]  load_addr,
    input  logic [7:0]      load_data,
    input  logic            start,
    input  logic            PCWre,
    input  logic            PCSrc,
    input  logic [31:0]     ExtImm,
    output logic [31:0]     pc_out,
    output logic [31:0]     instr,
    output logic [5:0]      opcode,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [15:0]     imm16,
    output logic            fetch_valid,
    output logic            halted,
    output logic            addr_err,
    output logic [1:0]      state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    localparam logic [31:0] HALT_WORD = 32'hFC00_0000;
    localparam logic [31:0] PC_MAX    = 32'(IMEM_BYTES - 4);

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic            err_q, err_d;
    logic            mem_we;
    logic [31:0]     npc;
    logic [LAW-1:0]  ra;
    logic [31:0]     fetch_word;
    logic [7:0]      imem_q [IMEM_BYTES];

    // Branch offset is a word offset; mod-2^32 add lets negative offsets go backward.
    assign npc = pc_q + 32'd4 + (PCSrc ? (ExtImm << 2) : 32'd0);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            S_RUN: begin
                if (!PCWre) begin
                    state_d = S_HALT;
                end else if (npc > PC_MAX) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    pc_d = npc;
                end
            end
            default: begin
                mem_we = load_en;
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = 32'd0;
                    err_d   = 1'b0;
                end else if (load_en) begin
                    state_d = S_LOAD;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end

    // Program memory survives Reset so a program can be rerun without reloading.
    always_ff @(posedge CLK) begin
        if (mem_we && !Reset) begin
            imem_q[load_addr] <= load_data;
        end
    end

    assign ra         = pc_q[LAW-1:0];
    assign fetch_word = {imem_q[ra], imem_q[ra + LAW'(1)],
                         imem_q[ra + LAW'(2)], imem_q[ra + LAW'(3)]};

    assign instr       = (state_q == S_RUN) ? fetch_word : HALT_WORD;
    assign opcode      = instr[31:26];
    assign rs          = instr[25:21];
    assign rt          = instr[20:16];
    assign rd          = instr[15:11];
    assign imm16       = instr[15:0];
    assign pc_out      = pc_q;
    assign fetch_valid = (state_q == S_RUN);
    assign halted      = (state_q == S_HALT);
    assign addr_err    = err_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a random
// branch walk, with expected {pc, instr, fetch_valid, halted, addr_err} queued per cycle.
module tb_instruction_fetch_unit;

    localparam int W = 67;
    localparam logic [31:0] HW = 32'hFC00_0000;

    logic        CLK = 1'b0;
    logic        Reset, load_en, start, PCWre, PCSrc;
    logic [6:0]  load_addr;
    logic [7:0]  load_data;
    logic [31:0] ExtImm;
    logic [31:0] pc_out, instr;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic        fetch_valid, halted, addr_err;
    logic [1:0]  state_o;

    int checks = 0;
    int passes = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got, e;
    logic [7:0]   mem_m [128];

    instruction_fetch_unit #(.IMEM_BYTES(128), .LAW(7)) dut (
        .CLK(CLK), .Reset(Reset), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .PCWre(PCWre), .PCSrc(PCSrc),
        .ExtImm(ExtImm), .pc_out(pc_out), .instr(instr), .opcode(opcode),
        .rs(rs), .rt(rt), .rd(rd), .imm16(imm16), .fetch_valid(fetch_valid),
        .halted(halted), .addr_err(addr_err), .state_o(state_o)
    );

    always #5 CLK = ~CLK;

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        load_en = 0; start = 0; PCWre = 0; PCSrc = 0; ExtImm = 0;
        load_addr = 0; load_data = 0;
    endtask

    task automatic load_byte(input logic [6:0] a, input logic [7:0] d);
        load_en = 1; load_addr = a; load_data = d;
        tick();
        load_en = 0;
        mem_m[a] = d;
    endtask

    task automatic load_word(input logic [6:0] a, input logic [31:0] w);
        load_byte(a,          w[31:24]);
        load_byte(a + 7'd1,   w[23:16]);
        load_byte(a + 7'd2,   w[15:8]);
        load_byte(a + 7'd3,   w[7:0]);
    endtask

    function automatic logic [31:0] word_m(input int a);
        return {mem_m[a], mem_m[a+1], mem_m[a+2], mem_m[a+3]};
    endfunction

    function automatic logic [W-1:0] ev(input logic [31:0] p, input logic [31:0] i,
                                        input logic fv, input logic h, input logic er);
        return {p, i, fv, h, er};
    endfunction

    function automatic logic [W-1:0] obs();
        return {pc_out, instr, fetch_valid, halted, addr_err};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        Reset = 1;
        tick(); tick();
        Reset = 0;
        exp_q.push_back(ev(32'd0, HW, 0, 0, 0));
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got === e) passes++; else $display("FAIL reset got=%h exp=%h", got, e);
        checks++;
        if (opcode === 6'h3F && state_o === 2'd0) passes++;
        else $display("FAIL reset_fields opcode=%h state=%0d exp opcode=3f state=0", opcode, state_o);
        // fill the whole memory so every fetch has a known model value
        for (int a = 0; a < 128; a++) load_byte(7'(a), 8'($urandom_range(0, 255)));
    endtask

    task automatic test_basic();
        load_word(7'd0, 32'h0401_0005);
        load_word(7'd4, HW);
        start = 1;
        exp_q.push_back(ev(32'd0, 32'h0401_0005, 1, 0, 0));
        tick(); start = 0;
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got === e) passes++; else $display("FAIL basic_start got=%h exp=%h", got, e);
        checks++;
        if (opcode === 6'b000001 && rs === 5'd0 && rt === 5'd1 && rd === 5'd0 && imm16 === 16'h0005) passes++;
        else $display("FAIL basic_fields got op=%h rs=%0d rt=%0d rd=%0d imm=%h exp op=01 rs=0 rt=1 rd=0 imm=0005",
                      opcode, rs, rt, rd, imm16);
        PCWre = 1;
        exp_q.push_back(ev(32'd4, HW, 1, 0, 0));
        tick();
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got === e) passes++; else $display("FAIL basic_seq got=%h exp=%h", got, e);
        PCWre = 0;
        exp_q.push_back(ev(32'd4, HW, 0, 1, 0));
        tick();
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got === e) passes++; else $display("FAIL basic_halt got=%h exp=%h", got, e);
    endtask

    task automatic test_branch();
        start = 1; tick(); start = 0;
        PCWre = 1; PCSrc = 0;
        tick();
        exp_q.push_back(ev(32'd8, word_m(8), 1, 0, 0));
        tick();
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got === e) passes++; else $display("FAIL branch_pc8 got=%h exp=%h", got, e);
        PCSrc = 1; ExtImm = 32'hFFFF_FFFE;
        exp_q.push_back(ev(32'd4, word_m(4), 1, 0, 0));
        tick();
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got === e) passes++; else $display("FAIL branch_back got=%h exp=%h", got, e);
        PCSrc = 0;
        tick();
        PCSrc = 1; ExtImm = 32'd1;
        exp_q.push_back(ev(32'd16, word_m(16), 1, 0, 0));
        tick();
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got === e) passes++; else $display("FAIL branch_fwd got=%h exp=%h", got, e);
        PCWre = 0; PCSrc = 0; ExtImm = 0;
        tick();
    endtask

    task automatic test_addr_err();
        start = 1; tick(); start = 0;
        PCWre = 1; PCSrc = 1; ExtImm = 32'd30;
        exp_q.push_back(ev(32'd124, word_m(124), 1, 0, 0));
        tick();
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got === e) passes++; else $display("FAIL boundary_124 got=%h exp=%h", got, e);
        PCSrc = 0;
        exp_q.push_back(ev(32'd124, HW, 0, 1, 1));
        tick();
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got === e) passes++; else $display("FAIL overflow_err got=%h exp=%h", got, e);
        exp_q.push_back(ev(32'd124, HW, 0, 1, 1));
        tick();
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got === e) passes++; else $display("FAIL halt_hold got=%h exp=%h", got, e);
        PCWre = 0; start = 1;
        exp_q.push_back(ev(32'd0, word_m(0), 1, 0, 0));
        tick(); start = 0;
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got === e) passes++; else $display("FAIL restart_clears got=%h exp=%h", got, e);
        PCWre = 1; PCSrc = 1; ExtImm = 32'hFFFF_FFFE;
        exp_q.push_back(ev(32'd0, HW, 0, 1, 1));
        tick();
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got === e) passes++; else $display("FAIL wrap_err got=%h exp=%h", got, e);
        idle_inputs();
    endtask

    task automatic test_reset_mid_run();
        start = 1; tick(); start = 0;
        PCWre = 1; PCSrc = 1; ExtImm = 32'd3;
        exp_q.push_back(ev(32'h10, word_m(16), 1, 0, 0));
        tick();
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got === e) passes++; else $display("FAIL run_to_10 got=%h exp=%h", got, e);
        Reset = 1;
        exp_q.push_back(ev(32'd0, HW, 0, 0, 0));
        tick(); Reset = 0;
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got === e && state_o === 2'd0) passes++;
        else $display("FAIL mid_reset got=%h state=%0d exp=%h state=0", got, state_o, e);
        idle_inputs(); start = 1;
        exp_q.push_back(ev(32'd0, word_m(0), 1, 0, 0));
        tick(); start = 0;
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got === e) passes++; else $display("FAIL mem_retained got=%h exp=%h", got, e);
    endtask

    task automatic test_run_load_ignored();
        load_en = 1; load_addr = 7'd0; load_data = 8'hFF; PCWre = 1; PCSrc = 0;
        exp_q.push_back(ev(32'd4, word_m(4), 1, 0, 0));
        tick();
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got === e) passes++; else $display("FAIL run_load_step got=%h exp=%h", got, e);
        idle_inputs();
        tick();
        start = 1;
        exp_q.push_back(ev(32'd0, word_m(0), 1, 0, 0));
        tick(); start = 0;
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got === e) passes++; else $display("FAIL imem0_unchanged got=%h exp=%h", got, e);
    endtask

    task automatic test_load_and_start();
        tick();
        load_byte(7'd0, 8'hA5);
        exp_q.push_back(ev(32'd0, HW, 0, 0, 0));
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got === e && state_o === 2'd1) passes++;
        else $display("FAIL halt_to_load got=%h state=%0d exp=%h state=1", got, state_o, e);
        start = 1;
        mem_m[1] = 8'h5A;
        exp_q.push_back(ev(32'd0, word_m(0), 1, 0, 0));
        load_en = 1; load_addr = 7'd1; load_data = 8'h5A;
        tick();
        idle_inputs();
        got = obs(); e = exp_q.pop_front(); checks++;
        if (got === e) passes++; else $display("FAIL load_and_start got=%h exp=%h", got, e);
    endtask

    task automatic test_random_walk();
        int mpc;
        int t;
        mpc = 0;
        PCWre = 1;
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 3) == 0 && mpc < 124) begin
                PCSrc = 0; ExtImm = $urandom();
                t = mpc / 4 + 1;
            end else begin
                PCSrc = 1;
                t = $urandom_range(0, 31);
                ExtImm = 32'(t - mpc / 4 - 1);
            end
            mpc = t * 4;
            exp_q.push_back(ev(32'(mpc), word_m(mpc), 1, 0, 0));
            tick();
            got = obs(); e = exp_q.pop_front(); checks++;
            if (got === e) passes++;
            else $display("FAIL random_step%0d got=%h exp=%h", n, got, e);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        Reset = 1;
        idle_inputs();
        test_reset();
        test_basic();
        test_branch();
        test_addr_err();
        test_reset_mid_run();
        test_run_load_ignored();
        test_load_and_start();
        test_random_walk();
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
